// File: rtl/display_pkg.sv
// Shared constants and helpers for the four-digit multiplexed display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] ANODES_OFF = 4'hF;

   typedef enum logic {
      PHASE_ON  = 1'b0,
      PHASE_OFF = 1'b1
   } blink_phase_t;

   // True when digit idx and every digit above it are zero; digit 0 is never a leading zero.
   function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] idx);
      logic z;
      z = 1'b0;
      case (idx)
         2'd3:    z = (d[15:12] == 4'd0);
         2'd2:    z = (d[15:8] == 8'd0);
         2'd1:    z = (d[15:4] == 12'd0);
         default: z = 1'b0;
      endcase
      return z;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 render blank.
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Pure lookup, no state.
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed display scanner with one dead cycle per slot and end-of-count blinking.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module display_scan
   import display_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 64
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic        end_condition,
   output logic [6:0]  segments,
   output logic [3:0]  anodes,
   output logic [1:0]  digit_sel
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [PW-1:0] presc_r;
   logic [BW-1:0] bcnt_r, bcnt_next_s;
   blink_phase_t  phase_r, phase_next_s;
   logic [1:0]    sel_r, sel_next_s;
   logic          started_r, blank_r, blank_next_s, tick_s;
   logic [3:0]    nibble_s, an_next_s, an_r;
   logic [6:0]    dec_s, seg_r;

   bcd_to_7seg u_dec (
      .bcd (nibble_s),
      .seg (dec_s)
   );

   // The first tick after reset opens digit 0's slot instead of advancing past it.
   always_comb begin
      tick_s     = (presc_r == PW'(SCAN_DIV - 1));
      sel_next_s = sel_r;
      if (tick_s) begin
         sel_next_s = started_r ? (sel_r + 2'd1) : 2'd0;
      end else begin
         sel_next_s = sel_r;
      end
      nibble_s = 4'd0;
      case (sel_next_s)
         2'd0:    nibble_s = digits[3:0];
         2'd1:    nibble_s = digits[7:4];
         2'd2:    nibble_s = digits[11:8];
         2'd3:    nibble_s = digits[15:12];
         default: nibble_s = 4'd0;
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      blank_next_s = lead_zero(digits, sel_next_s);
`else
      blank_next_s = 1'b0;
`endif
   end

   // Blink counter advances on scan ticks only while the countdown has finished.
   always_comb begin
      bcnt_next_s  = bcnt_r;
      phase_next_s = phase_r;
      if (!end_condition) begin
         bcnt_next_s  = '0;
         phase_next_s = PHASE_ON;
      end else if (tick_s) begin
         if (bcnt_r == BW'(BLINK_DIV - 1)) begin
            bcnt_next_s  = '0;
            phase_next_s = (phase_r == PHASE_ON) ? PHASE_OFF : PHASE_ON;
         end else begin
            bcnt_next_s = bcnt_r + BW'(1);
         end
      end else begin
         bcnt_next_s  = bcnt_r;
         phase_next_s = phase_r;
      end
   end

   // Anodes use the upcoming blink phase so a dropped end_condition relights on the next edge.
   always_comb begin
      an_next_s = ANODES_OFF;
      if (tick_s || !started_r || (phase_next_s == PHASE_OFF) || blank_r) begin
         an_next_s = ANODES_OFF;
      end else begin
         an_next_s = ~(4'b0001 << sel_r);
      end
   end

   // State and output registers.
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         presc_r   <= '0;
         sel_r     <= 2'd0;
         started_r <= 1'b0;
         blank_r   <= 1'b0;
         seg_r     <= SEG_BLANK;
         an_r      <= ANODES_OFF;
         bcnt_r    <= '0;
         phase_r   <= PHASE_ON;
      end else begin
         presc_r <= tick_s ? '0 : (presc_r + PW'(1));
         bcnt_r  <= bcnt_next_s;
         phase_r <= phase_next_s;
         an_r    <= an_next_s;
         if (tick_s) begin
            sel_r     <= sel_next_s;
            started_r <= 1'b1;
            blank_r   <= blank_next_s;
            seg_r     <= dec_s;
         end
      end
   end

   assign segments  = seg_r;
   assign anodes    = an_r;
   assign digit_sel = sel_r;

endmodule

// File: tb/tb_display_scan.sv
// Randomized bench for display_scan against a cycle-count based model of the scan schedule.
module tb_display_scan;

   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 2;

   logic        clock_in = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] digits = 16'h0000;
   logic        end_condition = 1'b0;
   logic [6:0]  segments;
   logic [3:0]  anodes;
   logic [1:0]  digit_sel;

   int checks = 0;
   int errors = 0;

   // model state: edges since release, digits captured at the last slot start, ticks seen while blinking
   int          n = 0;
   int          ticks_ec = 0;
   logic [15:0] held = 16'h0000;
   string       lit_segs [10];

   display_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
      .clock_in      (clock_in),
      .reset         (reset),
      .digits        (digits),
      .end_condition (end_condition),
      .segments      (segments),
      .anodes        (anodes),
      .digit_sel     (digit_sel)
   );

   always #5 clock_in = ~clock_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      logic [6:0] m;
      string s;
      int k;
      m = 7'h7F;
      if (v <= 4'd9) begin
         s = lit_segs[v];
         for (int i = 0; i < s.len(); i++) begin
            k = int'(s[i]) - 97;
            m[k] = 1'b0;
         end
      end
      return m;
   endfunction

   always @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         n = 0;
         ticks_ec = 0;
         held = 16'h0000;
      end else begin
         n++;
         if (n % SCAN_DIV == 0) held = digits;
         if (!end_condition) ticks_ec = 0;
         else if (n % SCAN_DIV == 0) ticks_ec++;
      end
   end

   always @(negedge clock_in) begin : cmp
      int s, idx;
      logic blk;
      logic [3:0] ean;
      logic [6:0] eseg;
      s    = n / SCAN_DIV;
      idx  = (s == 0) ? 0 : (s - 1) % 4;
      eseg = (s == 0) ? 7'h7F : seg_of(held[idx*4 +: 4]);
      blk  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx != 0 && (held >> (4 * idx)) == 16'd0) blk = 1'b1;
`endif
      if (s == 0 || n % SCAN_DIV == 0 || (ticks_ec / BLINK_DIV) % 2 == 1 || blk) ean = 4'hF;
      else ean = ~(4'b0001 << idx);
      check("segments", 32'(segments), 32'(eseg));
      check("anodes", 32'(anodes), 32'(ean));
      check("digit_sel", 32'(digit_sel), 32'(idx));
   end

   task automatic wait_for(input logic [1:0] sel, input logic [3:0] an, input string name);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clock_in);
         #1;
         if (digit_sel == sel && anodes == an) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s timeout waiting for sel %0d anodes %b", name, sel, an);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge clock_in);
      #2;
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] d;
      int r;
      for (int i = 0; i < 4; i++) begin
         r = $urandom_range(0, 19);
         d[i*4 +: 4] = (r < 6) ? 4'd0 : 4'(r % 16);
      end
      return d;
   endfunction

   initial begin
      lit_segs = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
      reset = 1'b0;
      step(3);
      check("reset_anodes", 32'(anodes), 32'h F);
      check("reset_segments", 32'(segments), 32'h7F);

      // basic scan of 1234 with literal pins
      digits = 16'h1234;
      reset  = 1'b1;
      repeat (3) @(posedge clock_in);
      @(negedge clock_in); #1;
      check("pre_tick_dark", 32'(anodes), 32'hF);
      @(negedge clock_in); #1;
      check("dead_cycle", 32'(anodes), 32'hF);
      check("slot0_seg", 32'(segments), 32'h19);
      @(negedge clock_in); #1;
      check("slot0_anode", 32'(anodes), 32'hE);
      repeat (4) @(negedge clock_in);
      #1;
      check("slot1_anode", 32'(anodes), 32'hD);
      check("slot1_seg", 32'(segments), 32'h30);
      step(20);

      digits = 16'h00A5;
      step(40);

      // blinking with all-zero digits, then release
      digits = 16'h0000;
      end_condition = 1'b1;
      step(70);
      end_condition = 1'b0;
      step(12);

      // mid-slot digit change holds until digit 0 comes round again
      digits = 16'h1237;
      wait_for(2'd0, 4'hE, "slot0_7");
      #1;
      digits = 16'h1238;
      @(negedge clock_in); #1;
      check("hold_7", 32'(segments), 32'h78);
      wait_for(2'd1, 4'hD, "slot1_after");
      wait_for(2'd0, 4'hE, "slot0_8");
      check("show_8", 32'(segments), 32'h00);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(1);
         if ($urandom_range(0, 9) == 0) digits = rand_digits();
         if ($urandom_range(0, 29) == 0) end_condition = ~end_condition;
      end
      end_condition = 1'b0;
      digits = 16'h1234;
      step(10);

      // reset during digit 2 lit window
      wait_for(2'd2, 4'hB, "slot2_lit");
      #1;
      reset = 1'b0;
      #1;
      check("async_anodes", 32'(anodes), 32'hF);
      check("async_segments", 32'(segments), 32'h7F);
      check("async_sel", 32'(digit_sel), 32'h0);
      step(2);
      reset = 1'b1;
      repeat (SCAN_DIV + 1) @(posedge clock_in);
      @(negedge clock_in); #1;
      check("first_after_reset_sel", 32'(digit_sel), 32'h0);
      check("first_after_reset_an", 32'(anodes), 32'hE);
      step(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
